vblank_update_arbiter: RTL and testbench



---
 rtl/vblank_update_arbiter_if.sv | 32 +++
 rtl/vblank_update_arbiter.sv | 173 +++++++++++++++++
 tb/tb_vblank_update_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vblank_update_arbiter_if.sv
// vblank_update_arbiter_if: request/grant and raster-status bundle between the
// update requesters and the vertical-blanking arbiter.
//   req         requester -> arbiter  level request per requester
//   done        requester -> arbiter  completion strobe (granted bit only)
//   clr_err     requester -> arbiter  synchronous clear of timeout_err
//   gnt         arbiter -> requester  one-hot grant or zero
//   vblank      arbiter -> requester  vertical blanking active
//   frame_start arbiter -> requester  one-cycle pulse at start of blanking
//   frame_cnt   arbiter -> requester  frames started since reset
//   timeout_err arbiter -> requester  sticky per-requester timeout flags
interface vblank_update_arbiter_if #(
   parameter int unsigned NREQ = 4
);
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] done;
   logic            clr_err;
   logic [NREQ-1:0] gnt;
   logic            vblank;
   logic            frame_start;
   logic [15:0]     frame_cnt;
   logic [NREQ-1:0] timeout_err;

   modport master (
      output req, done, clr_err,
      input  gnt, vblank, frame_start, frame_cnt, timeout_err
   );

   modport slave (
      input  req, done, clr_err,
      output gnt, vblank, frame_start, frame_cnt, timeout_err
   );
endinterface

// File: rtl/vblank_update_arbiter.sv
// vblank_update_arbiter: hands out at most one exclusive grant per requester per
// frame, only inside the vertical-blanking window of the raster, so shared
// display state never changes during active video. Keeps its own hc/vc raster
// counters in lockstep with the display timing generator.
// Ports:
//   dclk  pixel clock
//   rst   asynchronous active-high reset
//   bus   vblank_update_arbiter_if.slave (req/done/clr_err in; gnt, vblank,
//         frame_start, frame_cnt, timeout_err out)
// Build option: VBLANK_ARB_FIXED_PRIO_EN selects fixed priority (lowest eligible
// index wins); otherwise round-robin starting at the rr pointer.
module vblank_update_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned HPIXELS = 800,
   parameter int unsigned VLINES  = 521,
   parameter int unsigned VBP     = 31,
   parameter int unsigned VFP     = 511,
   parameter int unsigned TIMEOUT = 1024
) (
   input logic                  dclk,
   input logic                  rst,
   vblank_update_arbiter_if.slave bus
);

   localparam int unsigned IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned TW        = $clog2(TIMEOUT + 1);
   localparam int unsigned WIN_RESET = VBP * HPIXELS;
   localparam int unsigned WIN_LOAD  = (VLINES - VFP + VBP) * HPIXELS;
   localparam int unsigned WIN_MAX   = (WIN_LOAD > WIN_RESET) ? WIN_LOAD : WIN_RESET;
   localparam int unsigned WW        = $clog2(((WIN_MAX > TIMEOUT) ? WIN_MAX : TIMEOUT) + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GRANT = 2'd1;
   localparam logic [1:0] GAP   = 2'd2;

   logic [9:0]      hc, vc, hc_n, vc_n;
   logic            start_n, vblank_n;
   logic            vblank_r, frame_start_r;
   logic [15:0]     frame_cnt_r;
   logic [WW-1:0]   win_left;

   logic [1:0]      state, state_n;
   logic [NREQ-1:0] gnt_r, gnt_n, served, served_n, err_r, err_n;
   logic [NREQ-1:0] eligible, err_set, served_set;
   logic [IW-1:0]   idx, idx_n, ptr, ptr_n, base, sel;
   logic [TW-1:0]   timer, timer_n;
   logic            can_grant;

   // Next raster position; status flags are registered from it so they line
   // up with the counters in the same cycle.
   always_comb begin
      hc_n = hc + 10'd1;
      vc_n = vc;
      if (hc == 10'(HPIXELS - 1)) begin
         hc_n = '0;
         vc_n = (vc == 10'(VLINES - 1)) ? '0 : vc + 10'd1;
      end
      start_n  = (hc_n == '0) && (vc_n == 10'(VFP));
      vblank_n = (vc_n >= 10'(VFP)) || (vc_n < 10'(VBP));
   end

   // Raster counters, frame bookkeeping and remaining-window counter.
   always_ff @(posedge dclk or posedge rst) begin
      if (rst) begin
         hc            <= '0;
         vc            <= '0;
         vblank_r      <= 1'b1;
         frame_start_r <= 1'b0;
         frame_cnt_r   <= '0;
         win_left      <= WW'(WIN_RESET);
      end else begin
         hc            <= hc_n;
         vc            <= vc_n;
         vblank_r      <= vblank_n;
         frame_start_r <= start_n;
         if (start_n) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
            win_left    <= WW'(WIN_LOAD);
         end else if (vblank_r && (win_left != '0)) begin
            win_left    <= win_left - WW'(1);
         end
      end
   end

   // Requester selection: first eligible index at or after base, cyclically.
   always_comb begin
      eligible = bus.req & ~served;
`ifdef VBLANK_ARB_FIXED_PRIO_EN
      base = '0;
`else
      base = ptr;
`endif
      sel = '0;
      // Scan downwards so the lowest offset from base is the final assignment.
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (eligible[IW'((32'(base) + 32'(k)) % NREQ)])
            sel = IW'((32'(base) + 32'(k)) % NREQ);
      end
      // Only start a grant that is guaranteed to finish inside the window.
      can_grant = vblank_r && (win_left > WW'(TIMEOUT)) && (eligible != '0);
   end

   // Grant FSM next state. GAP is the guaranteed dead cycle after a grant; it
   // may already arbitrate so the next grant follows after exactly one idle cycle.
   always_comb begin
      state_n    = state;
      gnt_n      = gnt_r;
      idx_n      = idx;
      ptr_n      = ptr;
      timer_n    = timer;
      err_set    = '0;
      served_set = '0;
      case (state)
         IDLE, GAP: begin
            state_n = IDLE;
            if (can_grant) begin
               state_n = GRANT;
               gnt_n   = NREQ'(1) << sel;
               idx_n   = sel;
               timer_n = '0;
            end
         end
         GRANT: begin
            if (bus.done[idx] || !bus.req[idx] || !vblank_r ||
                (timer == TW'(TIMEOUT - 1))) begin
               state_n         = GAP;
               gnt_n           = '0;
               served_set[idx] = 1'b1;
               ptr_n           = (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);
               // Only a plain timeout flags an error; done wins a tie.
               err_set[idx]    = !bus.done[idx] && bus.req[idx] && vblank_r;
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
         end
      endcase
      served_n = start_n ? '0 : (served | served_set);
      err_n    = (err_r & ~{NREQ{bus.clr_err}}) | err_set;
   end

   // Grant FSM state.
   always_ff @(posedge dclk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         gnt_r  <= '0;
         idx    <= '0;
         ptr    <= '0;
         timer  <= '0;
         served <= '0;
         err_r  <= '0;
      end else begin
         state  <= state_n;
         gnt_r  <= gnt_n;
         idx    <= idx_n;
         ptr    <= ptr_n;
         timer  <= timer_n;
         served <= served_n;
         err_r  <= err_n;
      end
   end

   // Grant is killed immediately if blanking ends under it.
   assign bus.gnt         = gnt_r & {NREQ{vblank_r}};
   assign bus.vblank      = vblank_r;
   assign bus.frame_start = frame_start_r;
   assign bus.frame_cnt   = frame_cnt_r;
   assign bus.timeout_err = err_r;

endmodule

// File: tb/tb_vblank_update_arbiter.sv
// tb_vblank_update_arbiter: directed and randomized checks of the vblank
// arbiter on a shrunken raster, against a frame-level reference model.
module tb_vblank_update_arbiter;
   localparam int N  = 4;
   localparam int H  = 64;
   localparam int V  = 24;
   localparam int VB = 6;
   localparam int VF = 16;
   localparam int TO = 64;

   logic dclk = 1'b0;
   logic rst;

   vblank_update_arbiter_if #(.NREQ(N)) bus ();

   vblank_update_arbiter #(
      .NREQ(N), .HPIXELS(H), .VLINES(V), .VBP(VB), .VFP(VF), .TIMEOUT(TO)
   ) dut (
      .dclk(dclk),
      .rst (rst),
      .bus (bus)
   );

   always #20 dclk = ~dclk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state for the current cycle t.
   int          t, owner, glen, ptr;
   logic [N-1:0] m_served, m_err;
   logic [15:0]  m_fcnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h at t=%0d", tag, obs, exp, t);
      end
   endtask

   function automatic int f_vc(input int tt);
      return (tt / H) % V;
   endfunction

   function automatic bit f_vblank(input int tt);
      return (f_vc(tt) >= VF) || (f_vc(tt) < VB);
   endfunction

   function automatic bit f_fstart(input int tt);
      return ((tt % H) == 0) && (f_vc(tt) == VF);
   endfunction

   // Blanking cycles left until the window closes at (hc=0, vc=VB).
   function automatic int f_win(input int tt);
      int ft;
      ft = tt % (V * H);
      if (ft / H < VB) return VB * H - ft;
      if (ft / H >= VF) return (V + VB) * H - ft;
      return 0;
   endfunction

   task automatic model_reset();
      t = 0; owner = -1; glen = 0; ptr = 0;
      m_served = '0; m_err = '0; m_fcnt = '0;
   endtask

   task automatic check_outputs();
      logic [N-1:0] g;
      g = '0;
      if (owner >= 0 && f_vblank(t)) g[owner] = 1'b1;
      chk("gnt", bus.gnt, g);
      chk("vblank", bus.vblank, f_vblank(t));
      chk("frame_start", bus.frame_start, f_fstart(t));
      chk("frame_cnt", bus.frame_cnt, m_fcnt);
      chk("timeout_err", bus.timeout_err, m_err);
   endtask

   // Advance model and DUT by one cycle using the inputs held during cycle t.
   task automatic tick();
      int           o_n, gl_n;
      logic [N-1:0] set_s, new_e;
      bit           ended;
      o_n = owner; gl_n = glen; set_s = '0; new_e = '0; ended = 0;
      if (owner >= 0) begin
         if (bus.done[owner] || !bus.req[owner]) ended = 1;
         else if (!f_vblank(t)) ended = 1;
         else if (glen == TO) begin ended = 1; new_e[owner] = 1'b1; end
         else gl_n = glen + 1;
         if (ended) begin
            set_s[owner] = 1'b1;
            ptr = (owner + 1) % N;
            o_n = -1;
         end
      end else if (f_vblank(t) && f_win(t) > TO && (bus.req & ~m_served) != '0) begin
         for (int k = N - 1; k >= 0; k--)
            if (bus.req[(ptr + k) % N] && !m_served[(ptr + k) % N]) o_n = (ptr + k) % N;
         gl_n = 1;
      end
      m_err    = (bus.clr_err ? '0 : m_err) | new_e;
      m_served = f_fstart(t + 1) ? '0 : (m_served | set_s);
      if (f_fstart(t + 1)) m_fcnt = m_fcnt + 16'd1;
      owner = o_n; glen = gl_n;
      @(posedge dclk);
      @(negedge dclk);
      t++;
      check_outputs();
   endtask

   task automatic rand_inputs();
      for (int i = 0; i < N; i++) begin
         if (!bus.req[i]) begin
            if ($urandom_range(0, 39) == 0) bus.req[i] = 1'b1;
         end else if ((owner == i || m_served[i]) && $urandom_range(0, 9) == 0) begin
            bus.req[i] = 1'b0;
         end
      end
      bus.done    = ($urandom_range(0, 11) == 0) ? N'($urandom) : '0;
      bus.clr_err = ($urandom_range(0, 63) == 0);
   endtask

   // Asynchronous reset between clock edges, then release on a falling edge.
   task automatic apply_reset(input string tag);
      #5 rst = 1'b1;
      #1;
      chk({tag, "_gnt"}, bus.gnt, 0);
      chk({tag, "_fcnt"}, bus.frame_cnt, 0);
      chk({tag, "_err"}, bus.timeout_err, 0);
      chk({tag, "_vblank"}, bus.vblank, 1);
      chk({tag, "_fstart"}, bus.frame_start, 0);
      model_reset();
      @(negedge dclk);
      rst = 1'b0;
      check_outputs();
   endtask

   logic [N-1:0] order[$];
   logic [N-1:0] last_g;
   int           cnt, starts, w;
   bit           prev;

   initial begin
      rst = 1'b1; bus.req = '0; bus.done = '0; bus.clr_err = 1'b0;
      model_reset();
      repeat (3) @(negedge dclk);
      check_outputs();
      rst = 1'b0;
      check_outputs();

      // One-cycle grant latency inside the reset blanking window.
      while (t < 5) tick();
      bus.req = 4'b0100;
      tick();
      chk("lat_gnt", bus.gnt, 4'b0100);
      chk("lat_vblank", bus.vblank, 1);
      chk("lat_fcnt", bus.frame_cnt, 0);
      chk("lat_fstart", bus.frame_start, 0);
      repeat (3) tick();
      bus.done = 4'b0100;
      tick();
      bus.done = '0; bus.req = '0;
      tick();
      chk("rel_gnt", bus.gnt, 0);

      // Late request: win_left == TIMEOUT at (0, VB-1), held to next frame.
      while (t < (VB - 1) * H) tick();
      bus.req = 4'b0001;
      while (t < 10 * H) tick();
      chk("late_gnt_active", bus.gnt, 0);
      while (t < VF * H) tick();
      chk("late_fstart", bus.frame_start, 1);
      chk("late_fcnt", bus.frame_cnt, 1);
      chk("late_gnt_fs", bus.gnt, 0);
      tick();
      chk("late_gnt", bus.gnt, 4'b0001);
      bus.done = 4'b0001;
      tick();
      bus.done = '0; bus.req = '0;
      tick();

      // Round-robin from a fresh reset: two windows, done 5 cycles into each grant.
      apply_reset("rst1");
      bus.req = 4'hF; last_g = '0;
      while (t < VF * H + 100) begin
         bus.done = (owner >= 0 && glen == 5) ? (N'(1) << owner) : '0;
         tick();
         if (bus.gnt != '0 && bus.gnt != last_g) order.push_back(bus.gnt);
         last_g = bus.gnt;
      end
      bus.done = '0; bus.req = '0;
      chk("rr_count", order.size(), 8);
      for (int i = 0; i < 8; i++)
         chk($sformatf("rr_order%0d", i), (i < order.size()) ? order[i] : '0, 4'b0001 << (i % 4));

      // Timeout with clr_err in the same cycle: the new flag wins.
      while (t < 2000) tick();
      bus.req = 4'b0010; cnt = 0; starts = 0; prev = 0;
      while (t < V * H + VF * H + 300) begin
         bus.clr_err = (owner == 1 && glen == TO);
         tick();
         if (bus.gnt[1]) cnt++;
         if (bus.gnt[1] && !prev) starts++;
         prev = bus.gnt[1];
      end
      bus.clr_err = 1'b0;
      chk("to_len", cnt, TO);
      chk("to_grants", starts, 1);
      chk("to_err", bus.timeout_err, 4'b0010);
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      chk("clr_err", bus.timeout_err, 0);
      bus.req = '0;

      // done together with the timeout cycle counts as done.
      while (t < 3500) tick();
      bus.req = 4'b0100;
      while (t < 2 * V * H + VF * H + 200) begin
         bus.done = (owner == 2 && glen == TO) ? 4'b0100 : '0;
         tick();
      end
      bus.done = '0; bus.req = '0;
      chk("done_at_to_err", bus.timeout_err, 0);

      // Randomized traffic over several frames.
      while (t < 2 * V * H + VF * H + 200 + 4 * V * H) begin
         rand_inputs();
         tick();
      end
      bus.done = '0; bus.clr_err = 1'b0;

      // Reset in the middle of an active grant.
      bus.req = 4'hF; w = 0;
      while (!(owner >= 0 && glen >= 3) && w < 3000) begin
         tick();
         w++;
      end
      chk("mid_grant_reached", (owner >= 0) ? 1 : 0, 1);
      apply_reset("rst2");
      tick();
      chk("post_rst_gnt", bus.gnt, 4'b0001);
      bus.req = '0;
      repeat (20) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
